sudoku_game_ctrl: RTL and testbench

Parametrised game controller for an N x N Sudoku (N = BOX*BOX). It runs the menu, level-select, load, navigate, number-pick, victory and defeat flow. It owns the live board register, cursor, strike counter and win/lose detection, and sits between the debounced button front-end and the display/renderer.

---
 rtl/sudoku_game_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sudoku_game_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sudoku_game_ctrl.sv
// Sudoku game controller: menu/level/load/navigate/pick/win/lose flow over a live board register.
// Define CURSOR_WRAP_EN to make NAVIGATE cursor moves wrap instead of saturate.
module sudoku_game_ctrl #(
  parameter int BOX         = 3,
  parameter int VAL_W       = 4,
  parameter int MAX_STRIKES = 3,
  parameter int NUM_LEVELS  = 3,
  localparam int N      = BOX*BOX,
  localparam int CELLS  = N*N,
  localparam int CELL_W = VAL_W+1,
  localparam int BW     = CELLS*CELL_W,
  localparam int CW     = $clog2(N),
  localparam int LW     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int SW     = $clog2(MAX_STRIKES+1),
  localparam int IDX_W  = $clog2(BW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up_button,
  input  logic              down_button,
  input  logic              left_button,
  input  logic              right_button,
  input  logic              start_button,
  input  logic              a_button,
  input  logic              b_button,
  input  logic [BW-1:0]     initial_board,
  output logic [BW-1:0]     board,
  output logic [CW-1:0]     cursor_x,
  output logic [CW-1:0]     cursor_y,
  output logic [VAL_W-1:0]  selected_number,
  output logic [LW-1:0]     level,
  output logic [SW-1:0]     strikes,
  output logic [2:0]        state,
  output logic              error,
  output logic              win,
  output logic              lose
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, SELECT = 3'd1, LOAD = 3'd2, NAVIGATE = 3'd3,
    PICK = 3'd4, VICTORY = 3'd5, DEFEAT = 3'd6
  } state_t;

  localparam logic [CW-1:0]    MID  = CW'(N/2);
  localparam logic [CW-1:0]    LAST = CW'(N-1);
  localparam logic [VAL_W-1:0] VMAX = VAL_W'(N);

  state_t             state_q, state_d;
  logic [BW-1:0]      board_q, board_d;
  logic [CW-1:0]      cx_q, cx_d, cy_q, cy_d;
  logic [VAL_W-1:0]   sel_q, sel_d;
  logic [LW-1:0]      lvl_q, lvl_d;
  logic [SW-1:0]      strikes_q, strikes_d, strikes_inc;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx;
  logic [CELL_W-1:0]  cur_cell;
  logic               all_locked;

  // One-cell cursor step; dec takes priority over inc.
  function automatic logic [CW-1:0] step(input logic [CW-1:0] p, input logic dec, input logic inc);
`ifdef CURSOR_WRAP_EN
    if (dec)      step = (p == '0)   ? LAST : p - CW'(1);
    else if (inc) step = (p == LAST) ? '0   : p + CW'(1);
    else          step = p;
`else
    if (dec)      step = (p == '0)   ? p : p - CW'(1);
    else if (inc) step = (p == LAST) ? p : p + CW'(1);
    else          step = p;
`endif
  endfunction

  assign idx         = (IDX_W'(cy_q) * IDX_W'(N) + IDX_W'(cx_q)) * IDX_W'(CELL_W);
  assign cur_cell    = board_q[idx +: CELL_W];
  assign strikes_inc = strikes_q + SW'(1);

  always_comb begin
    all_locked = 1'b1;
    for (int i = 0; i < CELLS; i++) all_locked &= board_q[i*CELL_W + VAL_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      board_q   <= '0;
      cx_q      <= MID;
      cy_q      <= MID;
      sel_q     <= VAL_W'(1);
      lvl_q     <= '0;
      strikes_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      sel_q     <= sel_d;
      lvl_q     <= lvl_d;
      strikes_q <= strikes_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    sel_d     = sel_q;
    lvl_d     = lvl_q;
    strikes_d = strikes_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (start_button) state_d = SELECT;
      SELECT: begin
        if (up_button) begin
          if (lvl_q != '0) lvl_d = lvl_q - LW'(1);
        end else if (down_button) begin
          if (lvl_q != LW'(NUM_LEVELS-1)) lvl_d = lvl_q + LW'(1);
        end
        if (a_button) state_d = LOAD;
      end
      LOAD: begin
        board_d   = initial_board;
        strikes_d = '0;
        err_d     = 1'b0;
        cx_d      = MID;
        cy_d      = MID;
        sel_d     = VAL_W'(1);
        state_d   = NAVIGATE;
      end
      NAVIGATE: begin
        // A fully locked board wins before any button is honoured.
        if (all_locked) state_d = VICTORY;
        else begin
          cx_d = step(cx_q, left_button, right_button);
          cy_d = step(cy_q, up_button, down_button);
          if (a_button && !cur_cell[VAL_W]) state_d = PICK;
        end
      end
      PICK: begin
        if (a_button) begin
          if (sel_q == cur_cell[VAL_W-1:0]) begin
            board_d[idx +: CELL_W] = {1'b1, sel_q};
            err_d   = 1'b0;
            state_d = NAVIGATE;
          end else begin
            strikes_d = strikes_inc;
            err_d     = 1'b1;
            if (strikes_inc == SW'(MAX_STRIKES)) state_d = DEFEAT;
          end
        end else if (b_button) begin
          state_d = NAVIGATE;
        end else if (up_button) begin
          sel_d = (sel_q == VMAX) ? VAL_W'(1) : sel_q + VAL_W'(1);
          err_d = 1'b0;
        end else if (down_button) begin
          sel_d = (sel_q <= VAL_W'(1)) ? VMAX : sel_q - VAL_W'(1);
          err_d = 1'b0;
        end
      end
      VICTORY, DEFEAT: if (start_button) state_d = SELECT;
      default: state_d = IDLE;
    endcase
  end

  assign board           = board_q;
  assign cursor_x        = cx_q;
  assign cursor_y        = cy_q;
  assign selected_number = sel_q;
  assign level           = lvl_q;
  assign strikes         = strikes_q;
  assign state           = state_q;
  assign error           = err_q;
  assign win             = (state_q == VICTORY);
  assign lose            = (state_q == DEFEAT);

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Directed scoreboard bench for sudoku_game_ctrl (default parameters, 9x9 board).
module tb_sudoku_game_ctrl;
  localparam int N = 9, VAL_W = 4, CELL_W = 5, BW = 81*CELL_W;

  logic clk = 0, reset = 1;
  logic up_b = 0, dn_b = 0, lf_b = 0, rt_b = 0, st_b = 0, a_b = 0, b_b = 0;
  logic [BW-1:0] init_b = '0, board, brd_a, brd_b, exp_b;
  logic [3:0] cx, cy, seln;
  logic [1:0] lvl, strk;
  logic [2:0] st;
  logic err, win, lose;

  sudoku_game_ctrl dut (
    .clk(clk), .reset(reset),
    .up_button(up_b), .down_button(dn_b), .left_button(lf_b), .right_button(rt_b),
    .start_button(st_b), .a_button(a_b), .b_button(b_b),
    .initial_board(init_b), .board(board), .cursor_x(cx), .cursor_y(cy),
    .selected_number(seln), .level(lvl), .strikes(strk), .state(st),
    .error(err), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] ST = 7'b1000000, A = 7'b0100000, B = 7'b0010000,
                         UP = 7'b0001000, DN = 7'b0000100, LF = 7'b0000010, RT = 7'b0000001;
  localparam int O_ST = 0, O_CX = 1, O_CY = 2, O_SEL = 3, O_LVL = 4, O_STK = 5,
                 O_ERR = 6, O_WIN = 7, O_LOSE = 8, O_BRD = 9;

  typedef struct { string tag; int sel; logic [511:0] exp; } sb_t;
  sb_t q[$];
  int nchk = 0, nerr = 0;

  function automatic logic [511:0] obs(input int s);
    case (s)
      O_ST:   obs = 512'(st);
      O_CX:   obs = 512'(cx);
      O_CY:   obs = 512'(cy);
      O_SEL:  obs = 512'(seln);
      O_LVL:  obs = 512'(lvl);
      O_STK:  obs = 512'(strk);
      O_ERR:  obs = 512'(err);
      O_WIN:  obs = 512'(win);
      O_LOSE: obs = 512'(lose);
      default: obs = 512'(board);
    endcase
  endfunction

  task automatic ex(input string tag, input int s, input logic [511:0] v);
    sb_t e;
    e.tag = tag; e.sel = s; e.exp = v;
    q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [511:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sel);
      nchk++;
      assert (o === e.exp) else begin
        nerr++;
        $error("FAIL %s observed %0h expected %0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic press(input logic [6:0] m);
    @(negedge clk);
    {st_b, a_b, b_b, up_b, dn_b, lf_b, rt_b} = m;
    @(negedge clk);
    {st_b, a_b, b_b, up_b, dn_b, lf_b, rt_b} = '0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  // Valid solution grid, fully locked.
  function automatic logic [BW-1:0] solved();
    logic [BW-1:0] b;
    b = '0;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        b[(y*N+x)*CELL_W +: CELL_W] = {1'b1, 4'(((y*3 + y/3 + x) % 9) + 1)};
    return b;
  endfunction

  initial begin
    brd_a = solved();
    brd_a[(4*N+8)*CELL_W +: CELL_W] = {1'b0, 4'd7};
    brd_a[0 +: CELL_W] = {1'b0, 4'd5};
    brd_b = solved();
    brd_b[0 +: CELL_W] = {1'b0, 4'd5};
    init_b = brd_a;

    repeat (2) @(negedge clk);
    reset = 0;
    ex("rst_state", O_ST, 0); ex("rst_board", O_BRD, 0); ex("rst_cx", O_CX, 4);
    ex("rst_cy", O_CY, 4); ex("rst_sel", O_SEL, 1); ex("rst_lvl", O_LVL, 0);
    ex("rst_strk", O_STK, 0); ex("rst_err", O_ERR, 0); ex("rst_win", O_WIN, 0);
    ex("rst_lose", O_LOSE, 0);
    drain();

    press(ST); ex("to_select", O_ST, 1); drain();
    press(UP); ex("lvl_sat0", O_LVL, 0); drain();
    repeat (5) press(DN);
    ex("lvl_sat2", O_LVL, 2); drain();
    press(UP); ex("lvl_dec", O_LVL, 1); drain();
    press(UP | DN); ex("lvl_up_wins", O_LVL, 0); drain();
    press(A); ex("to_load", O_ST, 2); drain();
    idle();
    ex("to_nav", O_ST, 3); ex("load_board", O_BRD, 512'(brd_a)); ex("load_cx", O_CX, 4);
    ex("load_cy", O_CY, 4); ex("load_strk", O_STK, 0);
    drain();

    press(A); ex("a_locked_ignored", O_ST, 3); drain();
    repeat (4) press(RT);
    ex("right4", O_CX, 8); drain();
`ifdef CURSOR_WRAP_EN
    press(RT); ex("right_wrap", O_CX, 0); drain();
    press(LF); ex("left_wrap", O_CX, 8); drain();
`else
    press(RT); ex("right_sat", O_CX, 8); drain();
`endif
    press(A); ex("to_pick", O_ST, 4); drain();
    press(DN); ex("sel_wrap9", O_SEL, 9); drain();
    press(DN); ex("sel_8", O_SEL, 8); drain();
    press(DN | A); ex("a_beats_arrow_state", O_ST, 4); ex("a_beats_arrow_sel", O_SEL, 8);
    ex("wrong_strk1", O_STK, 1); drain();
    press(DN); ex("sel_7", O_SEL, 7); ex("arrow_clr_err", O_ERR, 0); drain();
    press(A);
    exp_b = brd_a;
    exp_b[(4*N+8)*CELL_W +: CELL_W] = {1'b1, 4'd7};
    ex("right_state", O_ST, 3); ex("right_err", O_ERR, 0); ex("right_board", O_BRD, 512'(exp_b));
    drain();
    press(A); ex("relocked_ignored", O_ST, 3); drain();

    press(UP | DN | LF | RT); ex("lf_beats_rt", O_CX, 7); ex("up_beats_dn", O_CY, 3); drain();
    repeat (3) press(UP | LF);
    ex("diag_cx", O_CX, 4); ex("diag_cy", O_CY, 0); drain();
    repeat (4) press(LF);
    ex("corner_cx", O_CX, 0); drain();
    press(A); ex("pick2", O_ST, 4); drain();
    press(A); ex("strk2", O_STK, 2); ex("err_set", O_ERR, 1); ex("stay_pick", O_ST, 4); drain();
    press(UP); ex("sel_up", O_SEL, 8); drain();
    press(A); ex("strk3", O_STK, 3); ex("defeat", O_ST, 6); ex("lose", O_LOSE, 1); drain();
    press(UP); ex("frozen_board", O_BRD, 512'(exp_b)); ex("frozen_strk", O_STK, 3); drain();
    press(ST); ex("defeat_restart", O_ST, 1); ex("lose_clr", O_LOSE, 0); drain();

    init_b = brd_b;
    press(A); idle();
    ex("load2_state", O_ST, 3); ex("load2_board", O_BRD, 512'(brd_b)); ex("load2_strk", O_STK, 0);
    ex("load2_err", O_ERR, 0); drain();
    repeat (4) press(UP | LF);
    press(A); ex("pick3", O_ST, 4); drain();
    press(B); ex("b_back", O_ST, 3); drain();
    press(A); repeat (4) press(UP);
    ex("sel5", O_SEL, 5); drain();
    press(A); ex("win_t_state", O_ST, 3); ex("win_t_flag", O_WIN, 0); drain();
    idle(); ex("win_t1_state", O_ST, 5); ex("win_t1_flag", O_WIN, 1); drain();
    press(ST); ex("win_restart", O_ST, 1); drain();

    press(A); idle();
    repeat (4) press(UP | LF);
    press(A); ex("pick4", O_ST, 4); drain();
    #2 reset = 1;
    #1 ex("async_rst_state", O_ST, 0); ex("async_rst_board", O_BRD, 0); drain();
    @(negedge clk); reset = 0;

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
